demux_1_to_4_tdm: RTL and testbench
===================================

// Module: demux_1_to_4_tdm
// PURPOSE
//  Time-division 1-to-4 demultiplexer, the receive end of the 4-to-1 lane mux path.
//  Takes a serialised word stream (lane 0..3 in slot order, slot 0 marked by in_sync).
//  Deposits each word into its lane and publishes all four lanes atomically once per frame.
//  Sits between the serial link front end and the parallel lane consumers.
// PARAMETERS
//  W      8   width of one lane word
//  CNT_W  16  width of frame_cnt (used only with DEMUX_FRAME_CNT_EN)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  in_data      in   W      serial word for the current slot
//  in_valid     in   1      in_data valid this cycle; a word is accepted when high
//  in_sync      in   1      qualifies in_data as slot 0 (meaningful only with in_valid)
//  Y            out  4*W    lane outputs; lane k = Y[k*W +: W]; held between frames
//  frame_valid  out  1      1-cycle pulse: Y was just updated with a complete frame
//  sync_err     out  1      1-cycle pulse: in_sync arrived mid-frame
//  locked       out  1      high in LOCKED state
// BEHAVIOUR
//  Reset (async, rst_n=0): state=HUNT, slot=0, shadow regs=0, Y=0, frame_valid=0,
//    sync_err=0, locked=0. Any in-flight partial frame is discarded; Y is not published.
//  State HUNT: words without in_sync are dropped.
//    in_valid&in_sync -> shadow[0]<=in_data, slot<=1, go LOCKED.
//  State LOCKED: each accepted word is written to shadow[slot]; slot<=slot+1 (2-bit, 3 wraps to 0).
//    On accept at slot 3: Y<={in_data,shadow[2],shadow[1],shadow[0]}; frame_valid=1 next cycle.
//    Latency: last word accepted at edge N -> Y/frame_valid visible after edge N (1 clock).
//    in_sync at slot 0: legal, optional (no error).
//    in_sync at slot!=0: sync_err pulses; partial frame is dropped (Y untouched, no frame_valid);
//      the word is taken as the new slot 0 (shadow[0]<=in_data, slot<=1); stays LOCKED.
//    in_valid=0: no state change; gaps of any length are allowed mid-frame.
//  Y changes only on frame completion; a consumer sampling Y on frame_valid sees a coherent frame.
//  frame_valid and sync_err are mutually exclusive (sync_err only at slot!=0, frame only at slot 3
//    without sync); both registered, default 0.
//  locked = (state==LOCKED); it never returns to HUNT except via reset.
//  No backpressure: the block accepts every valid word.
// CONFIGURATION
//  DEMUX_FRAME_CNT_EN defined: extra output port frame_cnt [CNT_W-1:0], reset 0,
//    +1 in the same cycle frame_valid is asserted, wraps 2^CNT_W-1 -> 0; sync_err does not count.
//  DEMUX_FRAME_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset, then words 0x11(sync),0x22,0x33,0x44 back-to-back -> 1 cycle later Y=0x44332211,
//     frame_valid pulse once, locked=1, sync_err=0.
//  2. In HUNT, send 0xAA,0xBB without sync then 0x01(sync),02,03,04 -> AA/BB dropped, Y=0x04030201.
//  3. Locked; send 0x10(sync),0x20, then 0x30 with sync -> sync_err pulse, Y unchanged, no
//     frame_valid; continue 0x40,0x50,0x60 -> Y=0x60504030.
//  4. Frame 0x01..0x04 with 3 idle cycles (in_valid=0) between each word -> same Y=0x04030201,
//     single frame_valid only after 0x04; Y holds its previous value until then.
//  5. Assert rst_n=0 asynchronously after slot 2 of a frame -> Y=0, locked=0 immediately; next
//     non-sync words are dropped until a sync word.
//  6. DEMUX_FRAME_CNT_EN, CNT_W=2: 5 complete frames -> frame_cnt 1,2,3,0,1; a sync_err frame
//     leaves frame_cnt unchanged.

Source files
------------

// File: rtl/demux_1_to_4_tdm.sv
// demux_1_to_4_tdm
//   Time-division 1-to-4 demultiplexer: receive end of the 4-to-1 lane mux.
//   Serial words arrive in slot order 0..3, with slot 0 flagged by in_sync.
//   Slots 0..2 are collected in shadow registers. When the slot 3 word is
//   accepted, all four lanes are published to Y in a single clock, so Y
//   always holds a coherent frame.
//   Optional feature macro: DEMUX_FRAME_CNT_EN adds a frame_cnt output that
//   counts published frames and wraps at 2^CNT_W.
module demux_1_to_4_tdm #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic [4*W-1:0]   Y,
`ifdef DEMUX_FRAME_CNT_EN
  output logic [CNT_W-1:0] frame_cnt,
`endif
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [1:0]          slot, slot_nxt;
  logic [2:0][W-1:0]   shadow_p0, shadow_nxt;
  logic [4*W-1:0]      y_p0, y_nxt;
  logic                vld_p0, vld_nxt;
  logic                err_p0, err_nxt;
`ifdef DEMUX_FRAME_CNT_EN
  logic [CNT_W-1:0]    cnt_p0, cnt_nxt;
`endif

  // Register stage: state, slot pointer, shadow lanes and published outputs.
  // Everything is reset because a reset must discard partial frames and clear Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      slot      <= 2'd0;
      shadow_p0 <= '0;
      y_p0      <= '0;
      vld_p0    <= 1'b0;
      err_p0    <= 1'b0;
`ifdef DEMUX_FRAME_CNT_EN
      cnt_p0    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      slot      <= slot_nxt;
      shadow_p0 <= shadow_nxt;
      y_p0      <= y_nxt;
      vld_p0    <= vld_nxt;
      err_p0    <= err_nxt;
`ifdef DEMUX_FRAME_CNT_EN
      cnt_p0    <= cnt_nxt;
`endif
    end
  end

  // Next-state logic: frame alignment, slot deposit and atomic frame publish.
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    shadow_nxt = shadow_p0;
    y_nxt      = y_p0;
    vld_nxt    = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      HUNT: begin
        // Words seen before the first sync marker have no known slot, so they are dropped.
        if (in_valid && in_sync) begin
          shadow_nxt[0] = in_data;
          slot_nxt      = 2'd1;
          state_nxt     = LOCKED;
        end
      end
      LOCKED: begin
        if (in_valid) begin
          if (in_sync && (slot != 2'd0)) begin
            // A mid-frame sync abandons the partial frame and realigns to the new slot 0.
            err_nxt       = 1'b1;
            shadow_nxt[0] = in_data;
            slot_nxt      = 2'd1;
          end else begin
            case (slot)
              2'd0: shadow_nxt[0] = in_data;
              2'd1: shadow_nxt[1] = in_data;
              2'd2: shadow_nxt[2] = in_data;
              default: begin
                // The slot 3 word goes directly to Y together with the three shadow lanes.
                y_nxt   = {in_data, shadow_p0[2], shadow_p0[1], shadow_p0[0]};
                vld_nxt = 1'b1;
              end
            endcase
            slot_nxt = slot + 2'd1;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

`ifdef DEMUX_FRAME_CNT_EN
  // Frame counter advances together with the frame_valid pulse and wraps naturally.
  always_comb begin
    cnt_nxt = cnt_p0;
    if (vld_nxt) cnt_nxt = cnt_p0 + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign frame_cnt = cnt_p0;
`endif

  assign Y           = y_p0;
  assign frame_valid = vld_p0;
  assign sync_err    = err_p0;
  assign locked      = (state == LOCKED);

endmodule

// File: tb/tb_demux_1_to_4_tdm.sv
// Directed testbench for demux_1_to_4_tdm.
// When DEMUX_FRAME_CNT_EN is defined, the DUT is built with CNT_W=2 so that
// counter wrap-around can be exercised.
module tb_demux_1_to_4_tdm;

  localparam int W = 8;
`ifdef DEMUX_FRAME_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_sync = 1'b0;
  logic [4*W-1:0] Y;
  logic           frame_valid;
  logic           sync_err;
  logic           locked;
`ifdef DEMUX_FRAME_CNT_EN
  logic [CNT_W-1:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  demux_1_to_4_tdm #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .Y           (Y),
`ifdef DEMUX_FRAME_CNT_EN
    .frame_cnt   (frame_cnt),
`endif
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then return 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_Y", Y, 0);
    check("rst_locked", locked, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_err", sync_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: back-to-back frame
    step(1, 1, 8'h11);
    check("t1_locked_after_sync", locked, 1);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    check("t1_fv_early", frame_valid, 0);
    check("t1_Y_early", Y, 0);
    step(1, 0, 8'h44);
    check("t1_Y", Y, 32'h44332211);
    check("t1_fv", frame_valid, 1);
    check("t1_err", sync_err, 0);
    idle();
    check("t1_fv_pulse_end", frame_valid, 0);
    check("t1_Y_hold", Y, 32'h44332211);

    // Test 2: hunting drops words that arrive without sync
    do_reset();
    step(1, 0, 8'hAA);
    step(1, 0, 8'hBB);
    check("t2_hunt_locked", locked, 0);
    check("t2_hunt_fv", frame_valid, 0);
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    step(1, 0, 8'h03);
    step(1, 0, 8'h04);
    check("t2_Y", Y, 32'h04030201);
    check("t2_fv", frame_valid, 1);

    // Test 3: a mid-frame sync realigns the frame
    step(1, 1, 8'h10);
    check("t3_sync_slot0_err", sync_err, 0);
    step(1, 0, 8'h20);
    step(1, 1, 8'h30);
    check("t3_err", sync_err, 1);
    check("t3_fv", frame_valid, 0);
    check("t3_Y_untouched", Y, 32'h04030201);
    check("t3_locked", locked, 1);
    step(1, 0, 8'h40);
    check("t3_err_pulse_end", sync_err, 0);
    step(1, 0, 8'h50);
    step(1, 0, 8'h60);
    check("t3_Y", Y, 32'h60504030);
    check("t3_fv2", frame_valid, 1);

    // Test 4: gaps between words
    step(1, 1, 8'h01);
    for (int w = 2; w <= 4; w++) begin
      for (int g = 0; g < 3; g++) begin
        idle();
        check("t4_gap_fv", frame_valid, 0);
        check("t4_gap_Y", Y, 32'h60504030);
      end
      step(1, 0, w[7:0]);
      if (w < 4) check("t4_word_fv", frame_valid, 0);
    end
    check("t4_Y", Y, 32'h04030201);
    check("t4_fv", frame_valid, 1);
    idle();
    check("t4_fv_end", frame_valid, 0);

    // Test 5: asynchronous reset in the middle of a frame
    step(1, 1, 8'h05);
    step(1, 0, 8'h06);
    step(1, 0, 8'h07);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_Y", Y, 0);
    check("t5_async_locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 8'h08);
    step(1, 0, 8'h09);
    check("t5_drop_locked", locked, 0);
    check("t5_drop_fv", frame_valid, 0);
    step(1, 1, 8'h0A);
    check("t5_relock", locked, 1);
    idle();

`ifdef DEMUX_FRAME_CNT_EN
    // Test 6: frame counter wrap with CNT_W=2
    do_reset();
    check("t6_cnt_rst", frame_cnt, 0);
    for (int f = 1; f <= 5; f++) begin
      step(1, 1, 8'hC0);
      step(1, 0, 8'hC1);
      step(1, 0, 8'hC2);
      step(1, 0, 8'hC3);
      check("t6_cnt", frame_cnt, f % 4);
    end
    step(1, 1, 8'h10);
    step(1, 0, 8'h20);
    step(1, 1, 8'h30);
    check("t6_err", sync_err, 1);
    check("t6_cnt_err", frame_cnt, 1);
    idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
